// File: rtl/section_sequencer.sv
// Section sequencer for a 4-way interleaved ADC stream.
// Labels samples by sub-ADC section and gates coefficient swaps to frame edges.
module section_sequencer #(
   parameter int NUM_SECTIONS = 4,
   parameter int FRAME_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en_i,
   input  logic               sync_i,
   input  logic               sample_valid_i,
   input  logic               upd_req_i,
   output logic [1:0]         adc_section,
   output logic               section_valid_o,
   output logic               coeff_swap_o,
   output logic               upd_ack_o,
   output logic [FRAME_W-1:0] frame_cnt_o,
   output logic               misalign_o,
   output logic [1:0]         state_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ALIGN = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] LAST    = 2'(NUM_SECTIONS - 1);

   logic [1:0] state;
   logic [1:0] cnt;
   logic       accept;
   logic [1:0] sec;
   logic       boundary;
   logic       realign;

   // Decide whether this cycle's sample is labelled, and with which section
   always_comb begin
      accept   = 1'b0;
      sec      = cnt;
      realign  = 1'b0;
      if (en_i && sample_valid_i) begin
         if (state == S_ALIGN) accept = sync_i;
         if (state == S_RUN)   accept = 1'b1;
      end
      if (sync_i) sec = 2'd0;
      if (state == S_RUN && accept && sync_i && cnt != 2'd0) realign = 1'b1;
      boundary = accept && (sec == LAST);
   end

   assign state_o = state;

   // Registered labelling, frame counting, swap grant and FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         cnt             <= 2'd0;
         adc_section     <= 2'd0;
         section_valid_o <= 1'b0;
         coeff_swap_o    <= 1'b0;
         upd_ack_o       <= 1'b0;
         frame_cnt_o     <= '0;
         misalign_o      <= 1'b0;
      end else begin
         section_valid_o <= accept;
         coeff_swap_o    <= boundary && upd_req_i;
         upd_ack_o       <= boundary && upd_req_i;
         if (accept) begin
            adc_section <= sec;
            cnt         <= (sec == LAST) ? 2'd0 : sec + 2'd1;
         end
         if (boundary) frame_cnt_o <= frame_cnt_o + 1'b1;
         if (realign) misalign_o <= 1'b1;
         case (state)
            S_IDLE: begin
               if (en_i) begin
                  state      <= S_ALIGN;
                  misalign_o <= 1'b0;
               end
            end
            S_ALIGN: begin
               if (!en_i) begin
                  state <= S_IDLE;
                  cnt   <= 2'd0;
               end else if (accept) begin
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (!en_i) begin
                  state <= S_IDLE;
                  cnt   <= 2'd0;
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= 2'd0;
            end
         endcase
      end
   end

endmodule
